// File: rtl/despread_pkg.sv
// Shared constants and types for the receive despread/unpack path.
// SPREAD_DEFAULT/CODE_DEFAULT must match the transmit Spread instance.
package despread_pkg;

   localparam int SPREAD_DEFAULT = 24;
   localparam logic [SPREAD_DEFAULT-1:0] CODE_DEFAULT = 24'hF35AC6;
   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE,
      TRACK
   } state_t;

   // Accumulator width that holds SPREAD signed chips without overflow.
   function automatic int acc_width(input int soft_w, input int spread);
      return soft_w + $clog2(spread) + 1;
   endfunction

endpackage

// File: rtl/chip_correlator.sv
// Correlates groups of SPREAD soft chips against the spreading code and
// decides one bit on the last chip of each group (combinational decision).
module chip_correlator #(
   parameter int SOFT_W = 12,
   parameter int SPREAD = 24,
   parameter logic [SPREAD-1:0] CODE = '0,
   parameter int ACC_W = 18
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic signed [SOFT_W-1:0] i_chip,
   input  logic                     i_valid,
   input  logic                     i_restart,
   output logic                     o_bit,
   output logic                     o_bit_valid
);

   localparam int CNT_W = $clog2(SPREAD);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SPREAD - 1);

   logic [CNT_W-1:0]        chip_cnt;
   logic [CNT_W-1:0]        chip_idx;
   logic                    code_bit;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] chip_ext;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] sum;

   // A restart chip is always chip 0, regardless of where the count stood.
   always_comb begin
      chip_idx    = i_restart ? '0 : chip_cnt;
      code_bit    = CODE[LAST - chip_idx];
      chip_ext    = {{(ACC_W - SOFT_W){i_chip[SOFT_W-1]}}, i_chip};
      term        = code_bit ? -chip_ext : chip_ext;
      sum         = (chip_idx == '0) ? term : acc + term;
      o_bit       = sum[ACC_W-1];
      o_bit_valid = i_valid && (chip_idx == LAST);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc      <= '0;
         chip_cnt <= '0;
      end else if (i_valid) begin
         acc      <= sum;
         chip_cnt <= (chip_idx == LAST) ? '0 : chip_idx + 1'b1;
      end
   end

endmodule

// File: rtl/despread_unpack.sv
// Receive despreader: correlates soft chips into bits, packs them MSB-first
// into words and presents each word on a valid/ready output.
module despread_unpack
   import despread_pkg::*;
#(
   parameter int SOFT_W = 12,
   parameter int SPREAD = SPREAD_DEFAULT,
   parameter logic [SPREAD-1:0] CODE = CODE_DEFAULT,
   parameter int OUT_W = BYTE_W
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic signed [SOFT_W-1:0] i_chip,
   input  logic                     i_valid,
   input  logic                     i_sof,
   output logic [OUT_W-1:0]         o_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic                     o_overflow,
   output logic                     o_locked
);

   localparam int ACC_W = acc_width(SOFT_W, SPREAD);
   localparam int BC_W = $clog2(OUT_W);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(OUT_W - 1);

   state_t           state;
   logic [OUT_W-2:0] shreg;
   logic [BC_W-1:0]  bit_cnt;

   logic             accept;
   logic             restart;
   logic             bit_dec;
   logic             bit_valid;
   logic [BC_W-1:0]  eff_cnt;
   logic [OUT_W-2:0] eff_sh;
   logic [OUT_W-1:0] word;
   logic             word_done;

   chip_correlator #(
      .SOFT_W (SOFT_W),
      .SPREAD (SPREAD),
      .CODE   (CODE),
      .ACC_W  (ACC_W)
   ) u_corr (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_chip      (i_chip),
      .i_valid     (accept),
      .i_restart   (restart),
      .o_bit       (bit_dec),
      .o_bit_valid (bit_valid)
   );

   // A resync drops the partial word before the current bit is packed.
   always_comb begin
      accept    = i_valid && ((state == TRACK) || i_sof);
      restart   = i_valid && i_sof;
      eff_cnt   = restart ? '0 : bit_cnt;
      eff_sh    = restart ? '0 : shreg;
      word      = {eff_sh, bit_dec};
      word_done = bit_valid && (eff_cnt == LAST_BIT);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         o_locked   <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         if (state == IDLE && i_valid && i_sof) begin
            state    <= TRACK;
            o_locked <= 1'b1;
         end

         if (accept) begin
            if (bit_valid) begin
               shreg   <= word[OUT_W-2:0];
               bit_cnt <= word_done ? '0 : eff_cnt + 1'b1;
            end else if (restart) begin
               shreg   <= '0;
               bit_cnt <= '0;
            end
         end

         // A completed word wins the register if the slot is free or freeing.
         if (word_done) begin
            if (!o_valid || i_ready) begin
               o_data  <= word;
               o_valid <= 1'b1;
            end else begin
               o_overflow <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_despread_unpack.sv
// Self-checking bench for despread_unpack: table-driven bytes, directed
// multi-cycle sequences and random traffic against a spec-level model.
module tb_despread_unpack;

   localparam int SPREAD = 24;
   localparam logic [23:0] CODE = 24'hF35AC6;

   logic              clk = 1'b0;
   logic              i_reset = 1'b1;
   logic signed [11:0] i_chip = '0;
   logic              i_valid = 1'b0;
   logic              i_sof = 1'b0;
   logic              i_ready = 1'b0;
   logic [7:0]        o_data;
   logic              o_valid;
   logic              o_overflow;
   logic              o_locked;

   always #5 clk = ~clk;

   despread_unpack #(
      .SOFT_W (12),
      .SPREAD (24),
      .CODE   (24'hF35AC6),
      .OUT_W  (8)
   ) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_chip     (i_chip),
      .i_valid    (i_valid),
      .i_sof      (i_sof),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_overflow (o_overflow),
      .o_locked   (o_locked)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: chips of the current bit, bits of current byte.
   bit m_lock, m_oval, m_ovf;
   int m_odata, m_byte, m_bits;
   int m_chips[$];
   int acc_q[$];

   typedef struct {
      int data;
      int mode;
      int tie;
      int exp;
   } vec_t;
   vec_t tbl[6];

   function automatic int code_bit(input int k);
      logic [23:0] c;
      c = CODE;
      return c[SPREAD-1-k] ? 1 : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model(input int chip, input bit v, input bit s, input bit r, input bit rst);
      int sum;
      int newb;
      bit done;
      done = 0;
      newb = 0;
      if (rst) begin
         m_lock = 0; m_oval = 0; m_ovf = 0; m_odata = 0;
         m_byte = 0; m_bits = 0; m_chips.delete();
         return;
      end
      if (v && (m_lock || s)) begin
         if (s) begin
            m_chips.delete(); m_bits = 0; m_byte = 0; m_lock = 1;
         end
         m_chips.push_back(chip);
         if (m_chips.size() == SPREAD) begin
            sum = 0;
            for (int k = 0; k < SPREAD; k++)
               sum += code_bit(k) ? -m_chips[k] : m_chips[k];
            m_byte = ((m_byte << 1) | (sum < 0 ? 1 : 0)) & 8'hFF;
            m_bits++;
            m_chips.delete();
            if (m_bits == 8) begin
               done = 1; newb = m_byte; m_bits = 0; m_byte = 0;
            end
         end
      end
      if (done) begin
         if (!m_oval || r) begin
            m_odata = newb; m_oval = 1;
         end else begin
            m_ovf = 1;
         end
      end else if (m_oval && r) begin
         m_oval = 0;
      end
   endtask

   task automatic step(input int c, input bit v, input bit s, input bit r, input bit rst);
      i_chip = c[11:0];
      i_valid = v;
      i_sof = s;
      i_ready = r;
      i_reset = rst;
      if (!rst && o_valid && r) acc_q.push_back(int'(o_data));
      @(posedge clk);
      model(c, v, s, r, rst);
      #1;
      check("o_valid", int'(o_valid), int'(m_oval));
      check("o_data", int'(o_data), m_odata);
      check("o_overflow", int'(o_overflow), int'(m_ovf));
      check("o_locked", int'(o_locked), int'(m_lock));
   endtask

   // mode 0: +-100, mode 1: 11 of 24 chips flipped per bit, mode 2: random magnitude
   task automatic send_byte(input int data, input int mode, input int tie_bit, input bit sof,
                            input bit rdy, input bit rdy_last, input int max_gap, input int n_chips);
      bit flip[24];
      bit d;
      int idx, nf, p, mag, val;
      for (int j = 0; j < 8; j++) begin
         d = bit'((data >> (7 - j)) & 1);
         for (int k = 0; k < 24; k++) flip[k] = 0;
         if (mode == 1) begin
            nf = 0;
            while (nf < 11) begin
               p = $urandom_range(0, 23);
               if (!flip[p]) begin
                  flip[p] = 1;
                  nf++;
               end
            end
         end
         for (int k = 0; k < 24; k++) begin
            idx = j * 24 + k;
            if (idx >= n_chips) return;
            mag = (mode == 2) ? int'($urandom_range(1, 2047)) : 100;
            val = ((d ? 1 : 0) ^ code_bit(k) ^ (flip[k] ? 1 : 0)) ? -mag : mag;
            if (j == tie_bit) val = 0;
            if (max_gap > 0)
               repeat ($urandom_range(0, max_gap))
                  step(int'($urandom_range(0, 4095)) - 2048, 0, bit'($urandom_range(0, 1)), rdy, 0);
            step(val, 1, sof && (idx == 0), (idx == 191) ? rdy_last : rdy, 0);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   int q0;
   int rd;

   initial begin
      model(0, 0, 0, 0, 1);

      // Reset state
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("reset_outputs", {o_valid, o_overflow, o_locked, o_data}, 0);

      // Clean byte with exact latency
      q0 = acc_q.size();
      send_byte('hA5, 0, -1, 1, 1, 1, 0, 192);
      check("clean_valid_latency", int'(o_valid), 1);
      check("clean_data", int'(o_data), 'hA5);
      step(0, 0, 0, 1, 0);
      check("clean_valid_pulse", int'(o_valid), 0);
      check("clean_overflow", int'(o_overflow), 0);
      check("clean_count", acc_q.size() - q0, 1);

      // Table of bytes
      tbl[0] = '{'hA5, 0, -1, 'hA5};
      tbl[1] = '{'h3C, 1, -1, 'h3C};
      tbl[2] = '{'hFF, 1, -1, 'hFF};
      tbl[3] = '{'hFF, 0, 2, 'hDF};
      tbl[4] = '{'h01, 0, 7, 'h00};
      rd = int'($urandom_range(0, 255));
      tbl[5] = '{rd, 2, -1, rd};
      for (int i = 0; i < 6; i++) begin
         q0 = acc_q.size();
         send_byte(tbl[i].data, tbl[i].mode, tbl[i].tie, 1, 1, 1, 0, 192);
         step(0, 0, 0, 1, 0);
         check("tbl_count", acc_q.size() - q0, 1);
         if (acc_q.size() > 0) check("tbl_byte", acc_q[$], tbl[i].exp);
      end

      // Backpressure: second byte dropped
      step(0, 0, 0, 0, 1);
      q0 = acc_q.size();
      send_byte('h12, 0, -1, 1, 0, 0, 0, 192);
      send_byte('h34, 0, -1, 0, 0, 0, 0, 192);
      step(0, 0, 0, 0, 0);
      check("bp_hold_data", int'(o_data), 'h12);
      check("bp_overflow", int'(o_overflow), 1);
      step(0, 0, 0, 1, 0);
      check("bp_valid_drop", int'(o_valid), 0);
      repeat (3) step(0, 0, 0, 1, 0);
      check("bp_count", acc_q.size() - q0, 1);
      if (acc_q.size() > 0) check("bp_byte", acc_q[$], 'h12);

      // Accept and complete in the same cycle
      step(0, 0, 0, 0, 1);
      q0 = acc_q.size();
      send_byte('h55, 0, -1, 1, 0, 0, 0, 192);
      send_byte('h56, 0, -1, 0, 0, 1, 0, 192);
      check("ac_valid", int'(o_valid), 1);
      check("ac_data", int'(o_data), 'h56);
      check("ac_overflow", int'(o_overflow), 0);
      check("ac_first", acc_q.size() - q0, 1);
      if (acc_q.size() > 0) check("ac_first_byte", acc_q[$], 'h55);
      step(0, 0, 0, 1, 0);
      if (acc_q.size() > 0) check("ac_second_byte", acc_q[$], 'h56);

      // Resync mid bit 5
      q0 = acc_q.size();
      send_byte('h9E, 0, -1, 1, 1, 1, 0, 5 * 24 + 10);
      send_byte('hC3, 0, -1, 1, 1, 1, 0, 192);
      step(0, 0, 0, 1, 0);
      check("resync_count", acc_q.size() - q0, 1);
      if (acc_q.size() > 0) check("resync_byte", acc_q[$], 'hC3);
      check("resync_overflow", int'(o_overflow), 0);

      // Random gaps
      q0 = acc_q.size();
      send_byte('h81, 0, -1, 0, 1, 1, 7, 192);
      step(0, 0, 0, 1, 0);
      check("gap_count", acc_q.size() - q0, 1);
      if (acc_q.size() > 0) check("gap_byte", acc_q[$], 'h81);

      // Reset after 100 chips, then chips ignored until next sof
      send_byte('h5A, 0, -1, 1, 1, 1, 0, 100);
      step(0, 0, 0, 1, 1);
      check("rst_outputs", {o_valid, o_overflow, o_locked, o_data}, 0);
      q0 = acc_q.size();
      send_byte('hA5, 0, -1, 0, 1, 1, 0, 192);
      step(0, 0, 0, 1, 0);
      check("rst_ignored", acc_q.size() - q0, 0);
      check("rst_unlocked", int'(o_locked), 0);
      send_byte('h66, 0, -1, 1, 1, 1, 0, 192);
      step(0, 0, 0, 1, 0);
      check("rst_relock_count", acc_q.size() - q0, 1);
      if (acc_q.size() > 0) check("rst_relock_byte", acc_q[$], 'h66);

      // Random traffic against the model
      for (int i = 0; i < 6; i++) begin
         send_byte(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), -1, i == 0,
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 192);
         repeat ($urandom_range(0, 2)) step(0, 0, 0, bit'($urandom_range(0, 1)), 0);
      end
      repeat (2) step(0, 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
